// File: rtl/c_descaler.sv
// c_descaler: iterative shift-add sqrt(2) descaler, result = a + a>>2 + a>>3 + a>>5 + a>>7.
// Optional macro C_DESCALER_SAT_EN saturates overflowing results to all ones instead of wrapping.
module c_descaler #(
    parameter int unsigned N = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [2**N-1:0]   a_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [2**N-1:0]   result_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);

    localparam int unsigned W = 2**N;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAcc  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [2:0]   idx_q, idx_d;
    logic [W-1:0] a_q, a_d;
    logic [W:0]   acc_q, acc_d;
    logic [W-1:0] result_q, result_d;

    logic [2:0]   shamt;
    logic [W:0]   term;
    logic [W:0]   sum;
    logic [W-1:0] sum_mapped;

    // Shift amount for the term added at the current index (index 0 is a itself).
    always_comb begin
        shamt = 3'd0;
        case (idx_q)
            3'd1:    shamt = 3'd2;
            3'd2:    shamt = 3'd3;
            3'd3:    shamt = 3'd5;
            3'd4:    shamt = 3'd7;
            default: shamt = 3'd0;
        endcase
    end

    always_comb begin
        term = {1'b0, a_q >> shamt};
        sum  = acc_q + term;
    end

`ifdef C_DESCALER_SAT_EN
    always_comb begin
        sum_mapped = sum[W] ? {W{1'b1}} : sum[W-1:0];
    end
`else
    always_comb begin
        sum_mapped = sum[W-1:0];
    end
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    acc_d   = {1'b0, a_i};
                    idx_d   = 3'd1;
                    state_d = StAcc;
                end
            end
            StAcc: begin
                acc_d = sum;
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd4) begin
                    result_d = sum_mapped;
                    idx_d    = 3'd0;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            idx_q    <= 3'd0;
            a_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    // Handshake outputs decode straight from the state register.
    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign result_o    = result_q;

endmodule

// File: tb/tb_c_descaler.sv
// Self-checking bench for c_descaler: vector table, randomized operands, reset-abort sequence.
module tb_c_descaler;

    localparam int unsigned N = 4;
    localparam int unsigned W = 2**N;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] result;
    logic         out_valid;
    logic         out_ready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    c_descaler #(.N(N)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .a_i         (a),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .result_o    (result),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] a;
        int          hold;
        logic [15:0] exp;
    } vec_t;

    // Reference: plain integer arithmetic, a/2^k equals the logical shift for unsigned a.
    function automatic logic [15:0] ref_model(input logic [15:0] op);
        int s;
        s = int'(op) + int'(op) / 4 + int'(op) / 8 + int'(op) / 32 + int'(op) / 128;
`ifdef C_DESCALER_SAT_EN
        if (s > 65535) s = 65535;
`else
        s = s % 65536;
`endif
        return 16'(s);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input logic [15:0] op, input int hold, input logic [15:0] exp,
                          output int acc_cyc);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        a         = op;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        for (int k = 1; k <= 4; k++) begin
            chk("busy_out_valid", {31'd0, out_valid}, 32'd0);
            chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
            // Garbage on the input side must not disturb the latched operand.
            in_valid = 1'($urandom);
            a        = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        chk("out_valid_latency", {31'd0, out_valid}, 32'd1);
        chk("result", {16'd0, result}, {16'd0, exp});
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom);
            a        = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_result", {16'd0, result}, {16'd0, exp});
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("result_kept", {16'd0, result}, {16'd0, exp});
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    vec_t vecs[6];
    int   acc_c;
    int   prev_c;
    int   prev_hold;

    initial begin
        rst_n     = 1'b0;
        a         = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        vecs[0] = '{a: 16'h1000, hold: 0, exp: 16'h16A0};
`ifdef C_DESCALER_SAT_EN
        vecs[1] = '{a: 16'hFFFF, hold: 0, exp: 16'hFFFF};
`else
        vecs[1] = '{a: 16'hFFFF, hold: 0, exp: 16'h69FB};
`endif
        vecs[2] = '{a: 16'h0003, hold: 0, exp: 16'h0003};
        vecs[3] = '{a: 16'h0000, hold: 0, exp: 16'h0000};
        vecs[4] = '{a: 16'h0080, hold: 10, exp: 16'h00B5};
        vecs[5] = '{a: 16'h0100, hold: 2, exp: 16'h016A};

        // Operands issued back-to-back: accept spacing is 6 cycles plus any output stall.
        prev_c    = -1;
        prev_hold = 0;
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].hold, vecs[i].exp, acc_c);
            if (prev_c >= 0) chk("accept_spacing", 32'(acc_c - prev_c), 32'(6 + prev_hold));
            prev_c    = acc_c;
            prev_hold = vecs[i].hold;
        end

        for (int i = 0; i < 30; i++) begin
            logic [15:0] op;
            op = 16'($urandom);
            if (i % 5 == 0) op[15:12] = 4'hF;
            run_op(op, int'($urandom_range(0, 3)), ref_model(op), acc_c);
        end

        // Asynchronous reset in mid-accumulation discards the pending result.
        a        = 16'h0200;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_result", {16'd0, result}, 32'd0);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("abort_no_out_valid", {31'd0, out_valid}, 32'd0);
        end
        out_ready = 1'b0;
        run_op(16'h0100, 0, 16'h016A, acc_c);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/c_descaler.md
C_DESCALER -- requirements
Module: c_descaler

Interface
REQ-001 Parameter N, default 4; data width W = 2**N bits (16 by default).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-004 a  input  W  unsigned operand; sampled only on an input handshake.
REQ-005 in_valid  input  1  operand a is valid.
REQ-006 in_ready  output  1  block can accept an operand.
REQ-007 result  output  W  unsigned descaled value; stable while out_valid=1.
REQ-008 out_valid  output  1  result is valid.
REQ-009 out_ready  input  1  consumer accepts result.

Function
REQ-010 The block SHALL compute result = a + (a>>2) + (a>>3) + (a>>5) + (a>>7), using logical right shifts; this is the sqrt(2) ~ 1.4140625 inverse of the butterfly 1/sqrt(2) twiddle scaling.
REQ-011 It SHALL be an iterative shift-add engine: one term per cycle into an accumulator of W+1 bits; no two terms are added in the same cycle.
REQ-012 States SHALL be IDLE, ACC and DONE, with a term index 0..4.
REQ-013 IDLE: in_ready=1, out_valid=0; when in_valid=1 at an edge: latch a, set acc=a (term 0), set index=1, go to ACC.
REQ-014 ACC: in_ready=0, out_valid=0; each edge adds the term for the current index (shifts 2, 3, 5, 7 for index 1..4) and increments the index; the edge that adds index 4 goes to DONE.
REQ-015 Latency: out_valid SHALL rise immediately after the 5th rising edge counted from the accepting edge, accepting edge included.
REQ-016 DONE: out_valid=1, in_ready=0, and result holds; on an edge with out_ready=1 the block returns to IDLE with out_valid=0.
REQ-017 No new operand SHALL be accepted in the cycle that DONE completes; in_ready rises only in IDLE, giving a minimum of 6 cycles per operand.
REQ-018 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE.
REQ-019 Arithmetic SHALL be exact in W+1 bits; the maximum sum (W=16: 92667) fits in 17 bits, and the output mapping is per REQ-024.
REQ-020 result SHALL be a registered output; there is no combinational path from any input to any output.

Reset
REQ-021 rst=0 SHALL immediately force state=IDLE, index=0, acc=0, result=0, out_valid=0, in_ready=1, independent of clk.
REQ-022 rst asserted during ACC or DONE SHALL abort the operation; the pending result is discarded and never presented.
REQ-023 After rst deasserts, the first rising edge with in_valid=1 SHALL be accepted normally.

Configuration
REQ-024 Macro C_DESCALER_SAT_EN: when defined, result = 0xFFFF (all ones, W bits) if acc bit W is set, else acc[W-1:0]; when undefined, result = acc[W-1:0] (wrap modulo 2**W).

Verification
REQ-025 a=0x1000, out_ready=1 -> result=0x16A0 (5792); out_valid after 5 edges; in_ready high again 1 cycle later.
REQ-026 a=0xFFFF -> with C_DESCALER_SAT_EN result=0xFFFF; without it result=0x69FB.
REQ-027 a=0x0003, then a=0x0000 back-to-back with in_valid held high -> results 0x0003 then 0x0000; second accept no earlier than 6 cycles after the first.
REQ-028 a=0x0080, out_ready=0 for 10 cycles after out_valid -> out_valid and result=0x00B5 (181) held throughout; in_ready stays 0; one cycle after out_ready=1, out_valid=0 and in_ready=1.
REQ-029 rst pulsed low during ACC (index 2), asynchronous to clk -> outputs go to reset values immediately; no out_valid follows; the next operand a=0x0100 -> result=0x016A.
REQ-030 in_valid toggling during ACC/DONE with differing a -> the latched operand is unaffected and the result matches the first accepted a.
